// File: rtl/upa_pk_gen_if.sv
// Handshake bundle between the IAQ/FMULT stage, upa_pk_gen and UPA1.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carried as plain valid/ready pairs.
// Ports: in_* side (DQ, SEZ, chan, init, clear_all), out_* side (PK0, PK1, SIGPK, DQSEZ, out_chan).
// Modports: slave = the upa_pk_gen block, master = the environment driving it.
interface upa_pk_gen_if #(
  parameter int CH_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] chan;
  logic            init;
  logic            clear_all;
  logic [15:0]     DQ;
  logic [14:0]     SEZ;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_chan;
  logic            PK0;
  logic            PK1;
  logic            SIGPK;
  logic [15:0]     DQSEZ;

  modport slave (
    input  in_valid, chan, init, clear_all, DQ, SEZ, out_ready,
    output in_ready, out_valid, out_chan, PK0, PK1, SIGPK, DQSEZ
  );

  modport master (
    output in_valid, chan, init, clear_all, DQ, SEZ, out_ready,
    input  in_ready, out_valid, out_chan, PK0, PK1, SIGPK, DQSEZ
  );
endinterface

// File: rtl/upa_pk_gen.sv
// G.726 ADDC: DQSEZ = DQ + SEZ, PK0/SIGPK from the sum, PK1 from a per-channel PK0 history.
// Latency: 1 cycle, outputs registered on the accept edge; 1 sample/cycle with out_ready high.
// Backpressure: in_ready = !out_valid | out_ready; a stalled output holds and leaves history untouched.
// Ports: clk, reset (async active-low), scan_in0..4/scan_enable/test_mode/scan_out0..4 (DFT),
//        bus (upa_pk_gen_if.slave) carrying the input and output handshakes.
// CHANNELS must not exceed 2**CH_W.
module upa_pk_gen #(
  parameter int CHANNELS = 32,
  parameter int CH_W     = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic scan_in0,
  input  logic scan_in1,
  input  logic scan_in2,
  input  logic scan_in3,
  input  logic scan_in4,
  input  logic scan_enable,
  input  logic test_mode,
  output logic scan_out0,
  output logic scan_out1,
  output logic scan_out2,
  output logic scan_out3,
  output logic scan_out4,
  upa_pk_gen_if.slave bus
);

  logic                accept;
  logic [15:0]         dq_mag;
  logic [15:0]         dqi;
  logic [15:0]         sezi;
  logic [15:0]         dqsez_n;
  logic                pk0_n;
  logic                pk1_n;
  logic                chan_ok;
  logic [CHANNELS-1:0] hist;

  // Scan stitching through every flop (history included) is done at DFT
  // insertion; the RTL keeps the chain ports and stays inert in functional mode.
  assign scan_out0 = scan_enable & test_mode & scan_in0;
  assign scan_out1 = scan_enable & test_mode & scan_in1;
  assign scan_out2 = scan_enable & test_mode & scan_in2;
  assign scan_out3 = scan_enable & test_mode & scan_in3;
  assign scan_out4 = scan_enable & test_mode & scan_in4;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Sign-magnitude to two's complement; 0x8000 (negative zero) maps to 0.
  assign dq_mag  = {1'b0, bus.DQ[14:0]};
  assign dqi     = bus.DQ[15] ? (16'd0 - dq_mag) : dq_mag;
  assign sezi    = {bus.SEZ[14], bus.SEZ};
  assign dqsez_n = dqi + sezi;
  assign pk0_n   = dqsez_n[15];

  // Out-of-range channels neither read nor write the history.
  assign chan_ok = 32'(bus.chan) < CHANNELS;
  assign pk1_n   = !bus.init && chan_ok && hist[bus.chan];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.out_chan  <= '0;
      bus.PK0       <= 1'b0;
      bus.PK1       <= 1'b0;
      bus.SIGPK     <= 1'b0;
      bus.DQSEZ     <= 16'd0;
      hist          <= '0;
    end else begin
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_chan  <= bus.chan;
        bus.PK0       <= pk0_n;
        bus.PK1       <= pk1_n;
        bus.SIGPK     <= (dqsez_n == 16'd0);
        bus.DQSEZ     <= dqsez_n;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      // The later assignment wins: an accept on the clear edge keeps its PK0.
      if (bus.clear_all) begin
        hist <= '0;
      end
      if (accept && chan_ok) begin
        hist[bus.chan] <= pk0_n;
      end
    end
  end

endmodule

// File: tb/tb_upa_pk_gen.sv
// Bench for upa_pk_gen: vector table through a scoreboard, plus hold and mid-stream reset sequences.
module tb_upa_pk_gen;

  typedef struct {
    logic [4:0]  chan;
    logic        init;
    logic        clr;
    logic [15:0] dq;
    logic [14:0] sez;
    logic [15:0] e_dqsez;
    logic        e_pk0;
    logic        e_pk1;
    logic        e_sig;
  } vec_t;

  logic clk;
  logic reset;
  logic so0, so1, so2, so3, so4;
  int   checks;
  int   errors;
  int   pushed;
  int   popped;
  vec_t exp_q[$];
  vec_t tbl[20];

  upa_pk_gen_if #(.CH_W(5)) bus ();

  upa_pk_gen #(.CHANNELS(32), .CH_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (1'b0),
    .scan_in1    (1'b0),
    .scan_in2    (1'b0),
    .scan_in3    (1'b0),
    .scan_in4    (1'b0),
    .scan_enable (1'b0),
    .test_mode   (1'b0),
    .scan_out0   (so0),
    .scan_out1   (so1),
    .scan_out2   (so2),
    .scan_out3   (so3),
    .scan_out4   (so4),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one sample; push its expectation when the accept edge is certain.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    bus.chan      = v.chan;
    bus.init      = v.init;
    bus.clear_all = v.clr;
    bus.DQ        = v.dq;
    bus.SEZ       = v.sez;
    bus.in_valid  = 1'b1;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout chan=%0d actual=no_accept required=accept", v.chan);
    end else begin
      exp_q.push_back(v);
      pushed++;
      @(posedge clk);
    end
    #1;
    bus.in_valid  = 1'b0;
    bus.init      = 1'b0;
    bus.clear_all = 1'b0;
  endtask

  // Scoreboard: a transfer happens on the next edge whenever valid & ready here.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=dqsez_%h required=no_output", bus.DQSEZ);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          popped++;
          chk($sformatf("sb_out_ch%0d_dq%h", e.chan, e.dq),
              {8'd0, bus.out_chan, bus.DQSEZ, bus.PK0, bus.PK1, bus.SIGPK},
              {8'd0, e.chan, e.e_dqsez, e.e_pk0, e.e_pk1, e.e_sig});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t h1, h2, h3, r1, r2;
    checks = 0;
    errors = 0;
    pushed = 0;
    popped = 0;

    // chan, init, clr, DQ, SEZ, DQSEZ, PK0, PK1, SIGPK
    tbl[0]  = '{5'd0,  1'b0, 1'b0, 16'h0010, 15'h0020, 16'h0030, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{5'd0,  1'b0, 1'b0, 16'h8030, 15'h0010, 16'hFFE0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{5'd0,  1'b0, 1'b0, 16'h8000, 15'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{5'd0,  1'b0, 1'b0, 16'h8001, 15'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{5'd1,  1'b0, 1'b0, 16'h0001, 15'h0000, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{5'd0,  1'b0, 1'b0, 16'h0010, 15'h7FF0, 16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{5'd1,  1'b0, 1'b0, 16'h0002, 15'h0001, 16'h0003, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{5'd3,  1'b0, 1'b0, 16'h8005, 15'h0000, 16'hFFFB, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{5'd3,  1'b1, 1'b0, 16'h0005, 15'h0000, 16'h0005, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{5'd3,  1'b0, 1'b0, 16'h8001, 15'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{5'd3,  1'b1, 1'b0, 16'h8002, 15'h0000, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{5'd3,  1'b0, 1'b0, 16'h0001, 15'h0000, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{5'd5,  1'b0, 1'b0, 16'h8001, 15'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{5'd2,  1'b0, 1'b1, 16'h8001, 15'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{5'd2,  1'b0, 1'b0, 16'h0001, 15'h0000, 16'h0001, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{5'd5,  1'b0, 1'b0, 16'h0001, 15'h0000, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{5'd4,  1'b0, 1'b0, 16'h7FFF, 15'h3FFF, 16'hBFFE, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{5'd4,  1'b0, 1'b0, 16'hFFFF, 15'h4000, 16'h4001, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{5'd31, 1'b0, 1'b0, 16'h8010, 15'h0000, 16'hFFF0, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{5'd31, 1'b0, 1'b0, 16'h0001, 15'h0000, 16'h0001, 1'b0, 1'b1, 1'b0};

    h1 = '{5'd6, 1'b0, 1'b0, 16'h8001, 15'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    h2 = '{5'd6, 1'b0, 1'b0, 16'h0001, 15'h0000, 16'h0001, 1'b0, 1'b1, 1'b0};
    h3 = '{5'd6, 1'b0, 1'b0, 16'h0003, 15'h0000, 16'h0003, 1'b0, 1'b0, 1'b0};
    r1 = '{5'd7, 1'b0, 1'b0, 16'h8001, 15'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    r2 = '{5'd7, 1'b0, 1'b0, 16'h0001, 15'h0000, 16'h0001, 1'b0, 1'b0, 1'b0};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.chan      = '0;
    bus.init      = 1'b0;
    bus.clear_all = 1'b0;
    bus.DQ        = 16'd0;
    bus.SEZ       = 15'd0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {7'd0, bus.out_valid, bus.out_chan, bus.DQSEZ, bus.PK0, bus.PK1, bus.SIGPK}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back table with out_ready held high.
    for (int i = 0; i < 20; i++) send(tbl[i]);
    repeat (3) @(negedge clk);

    // Output stall: in_ready low, outputs frozen, history untouched.
    bus.out_ready = 1'b0;
    send(h1);
    fork
      send(h2);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          #1;
          chk($sformatf("hold_cycle%0d", k),
              {12'd0, bus.in_ready, bus.out_valid, bus.DQSEZ, bus.PK0, bus.PK1},
              {12'd0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0});
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    send(h3);
    repeat (3) @(negedge clk);

    // Reset asserted while an output is pending.
    bus.out_ready = 1'b0;
    send(r1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midreset_outputs",
        {7'd0, bus.out_valid, bus.out_chan, bus.DQSEZ, bus.PK0, bus.PK1, bus.SIGPK}, 32'd0);
    exp_q.delete();
    pushed--;
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send(r2);
    repeat (3) @(negedge clk);

    chk("sb_drained", exp_q.size(), 32'd0);
    chk("sb_count", popped, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
